restoring_divider: RTL and testbench
====================================

RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have start, input, 1, division request, sampled only in IDLE or DONE.
REQ-004 SHALL have dividend, input, 16, unsigned dividend, captured when start is accepted.
REQ-005 SHALL have divisor, input, 16, unsigned divisor, captured when start is accepted.
REQ-006 SHALL have quotient, output, 16, registered result.
REQ-007 SHALL have remainder, output, 16, registered result.
REQ-008 SHALL have busy, output, 1, high while in ITER.
REQ-009 SHALL have done, output, 1, high for exactly one cycle when results become valid.
REQ-010 SHALL have dbz, output, 1, divide-by-zero flag for the current result.

Function
REQ-011 SHALL implement FSM states IDLE, ITER, DONE.
REQ-012 SHALL, in IDLE or DONE with start=1 and divisor!=0, load M=divisor, Q=dividend, A=0 (17 bits), count=16, clear dbz, and go to ITER.
REQ-013 SHALL, in ITER, each cycle: shift {A,Q} left 1; A=A-{0,M}; if A[16]=1, restore A and set Q[0]=0, else keep A and set Q[0]=1; count=count-1.
REQ-014 SHALL go from ITER to DONE on the edge where count reaches 0, after exactly 16 ITER cycles.
REQ-015 SHALL, in DONE, drive quotient=Q and remainder=A[15:0], assert done for that one cycle, and go to IDLE next cycle unless start=1.
REQ-016 SHALL assert done exactly 17 rising edges after the edge that accepted start; busy SHALL be high for the 16 cycles between.
REQ-017 SHALL hold quotient, remainder and dbz stable from DONE until the next accepted start.
REQ-018 SHALL, on start with divisor=0, skip ITER, go directly to DONE, set quotient=16'hFFFF, remainder=dividend, dbz=1; done SHALL occur 1 edge after acceptance.
REQ-019 SHALL ignore start while in ITER; the operation in progress SHALL be unaffected.
REQ-020 SHALL accept start in DONE (back-to-back) and begin the new operation, with done low in the following cycle.
REQ-021 SHALL keep dividend/divisor changes during ITER from affecting the result; only captured values are used.
REQ-022 SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every divisor!=0.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, enter IDLE and clear A, Q, M, count, quotient, remainder, busy, done and dbz to 0.
REQ-024 SHALL, on reset during ITER or DONE, abort the operation without asserting done; start SHALL be ignored while rst_n=0.
REQ-025 SHALL leave outputs in their reset values until the first completed operation after reset.

Verification
REQ-026 SHALL cover 100/7: start accepted at edge N -> done at edge N+17, quotient=14, remainder=2, dbz=0, busy high for 16 cycles.
REQ-027 SHALL cover 16'hFFFF/1 giving quotient=16'hFFFF, remainder=0; 5/9 giving quotient=0, remainder=5; 16'hFFFF/16'hFFFF giving quotient=1, remainder=0.
REQ-028 SHALL cover 16'h1234/0 -> done at edge N+1, quotient=16'hFFFF, remainder=16'h1234, dbz=1, busy never high.
REQ-029 SHALL cover start pulsed with different operands at ITER cycle 5 -> ignored; 100/7 result unchanged, done still at N+17.
REQ-030 SHALL cover rst_n=0 for one cycle at ITER cycle 8 -> next cycle IDLE, all outputs 0, no done; then 200/3 -> quotient=66, remainder=2.
REQ-031 SHALL cover back-to-back operation, 1000/10 then 9/4 with start held in DONE -> results 100,0 then 2,1; done pulses 17 edges apart.

Source files
------------

// File: rtl/restoring_divider.sv
// 16-bit unsigned restoring divider: one quotient bit per cycle over 16 ITER cycles.
// Divide-by-zero bypasses iteration and reports quotient all-ones with the dividend as remainder.
module restoring_divider (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [15:0] divisor,
   output logic [15:0] quotient,
   output logic [15:0] remainder,
   output logic        busy,
   output logic        done,
   output logic        dbz
);

   typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

   state_e      state_q, state_d;
   logic [16:0] a_q, a_d;
   logic [15:0] q_q, q_d;
   logic [15:0] m_q, m_d;
   logic [4:0]  count_q, count_d;
   logic [15:0] quotient_q, quotient_d;
   logic [15:0] remainder_q, remainder_d;
   logic        dbz_q, dbz_d;

   logic [16:0] a_sh, diff, a_it;
   logic [15:0] q_it;

   always_comb begin
      // One restoring step on the shifted partial remainder; diff[16] flags a negative trial.
      a_sh = {a_q[15:0], q_q[15]};
      diff = a_sh - {1'b0, m_q};
      if (diff[16]) begin
         a_it = a_sh;
         q_it = {q_q[14:0], 1'b0};
      end else begin
         a_it = diff;
         q_it = {q_q[14:0], 1'b1};
      end

      state_d     = state_q;
      a_d         = a_q;
      q_d         = q_q;
      m_d         = m_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;

      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               if (divisor == 16'd0) begin
                  quotient_d  = 16'hFFFF;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  state_d     = StDone;
               end else begin
                  m_d     = divisor;
                  q_d     = dividend;
                  a_d     = 17'd0;
                  count_d = 5'd16;
                  dbz_d   = 1'b0;
                  state_d = StIter;
               end
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StIter: begin
            a_d     = a_it;
            q_d     = q_it;
            count_d = count_q - 5'd1;
            if (count_q == 5'd1) begin
               quotient_d  = q_it;
               remainder_d = a_it[15:0];
               state_d     = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         a_q         <= 17'd0;
         q_q         <= 16'd0;
         m_q         <= 16'd0;
         count_q     <= 5'd0;
         quotient_q  <= 16'd0;
         remainder_q <= 16'd0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         q_q         <= q_d;
         m_q         <= m_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign dbz       = dbz_q;
   assign busy      = (state_q == StIter);
   assign done      = (state_q == StDone);

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench: directed corner cases plus random operands against an arithmetic model.
module tb_restoring_divider;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] dividend, divisor;
   logic [15:0] quotient, remainder;
   logic        busy, done, dbz;

   int tests_run    = 0;
   int tests_failed = 0;

   restoring_divider dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .dbz       (dbz)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge where done is seen.
   // lat counts edges from acceptance to the edge that samples done high.
   task automatic run_op(input logic [15:0] dd, input logic [15:0] dv, input int glitch_at,
                         output int lat, output int busy_cnt);
      start    = 1'b1;
      dividend = dd;
      divisor  = dv;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cnt++;
         dividend = 16'($urandom);
         divisor  = 16'($urandom);
         start    = (lat == glitch_at);
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
   endtask

   task automatic op_and_check(input string tag, input logic [15:0] dd, input logic [15:0] dv,
                               input int glitch_at);
      int lat, bc;
      logic [15:0] eq, er;
      logic        ez;
      run_op(dd, dv, glitch_at, lat, bc);
      if (dv == 16'd0) begin
         eq = 16'hFFFF; er = dd; ez = 1'b1;
      end else begin
         eq = dd / dv; er = dd % dv; ez = 1'b0;
      end
      check_eq({tag, " quotient"}, 32'(quotient), 32'(eq));
      check_eq({tag, " remainder"}, 32'(remainder), 32'(er));
      check_eq({tag, " dbz"}, 32'(dbz), 32'(ez));
      check_eq({tag, " latency"}, 32'(lat), (dv == 16'd0) ? 32'd1 : 32'd17);
      check_eq({tag, " busy cycles"}, 32'(bc), (dv == 16'd0) ? 32'd0 : 32'd16);
   endtask

   initial begin
      int lat, bc, saw_done;
      logic [15:0] dd, dv;
      rst_n = 1'b0; start = 1'b1; dividend = 16'd55; divisor = 16'd5;
      repeat (3) @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      check_eq("reset quotient", 32'(quotient), 32'd0);
      check_eq("reset remainder", 32'(remainder), 32'd0);
      check_eq("reset busy", 32'(busy), 32'd0);
      check_eq("reset done", 32'(done), 32'd0);
      check_eq("reset dbz", 32'(dbz), 32'd0);
      @(negedge clk);
      check_eq("idle outputs held", 32'({quotient, remainder}), 32'd0);

      op_and_check("100/7", 16'd100, 16'd7, -1);
      @(negedge clk);
      check_eq("done one cycle", 32'(done), 32'd0);
      check_eq("result held", 32'({quotient, remainder}), {16'd14, 16'd2});
      op_and_check("ffff/1", 16'hFFFF, 16'd1, -1);
      @(negedge clk);
      op_and_check("5/9", 16'd5, 16'd9, -1);
      @(negedge clk);
      op_and_check("ffff/ffff", 16'hFFFF, 16'hFFFF, -1);
      @(negedge clk);
      op_and_check("1234/0", 16'h1234, 16'd0, -1);
      @(negedge clk);
      check_eq("dbz held", 32'({dbz, quotient}), {15'd0, 1'b1, 16'hFFFF});
      op_and_check("start ignored in iter", 16'd100, 16'd7, 5);
      @(negedge clk);

      // Reset during iteration aborts without a done pulse.
      start = 1'b1; dividend = 16'd100; divisor = 16'd7;
      @(posedge clk);
      repeat (8) @(negedge clk);
      start = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("abort outputs", 32'({quotient, remainder}), 32'd0);
      check_eq("abort flags", 32'({busy, done, dbz}), 32'd0);
      saw_done = 0;
      repeat (20) begin
         @(negedge clk);
         if (done || busy) saw_done++;
      end
      check_eq("no done after abort", 32'(saw_done), 32'd0);
      op_and_check("200/3", 16'd200, 16'd3, -1);
      @(negedge clk);

      // Back-to-back: second start issued while in DONE.
      op_and_check("1000/10", 16'd1000, 16'd10, -1);
      run_op(16'd9, 16'd4, -1, lat, bc);
      check_eq("b2b spacing", 32'(lat), 32'd17);
      check_eq("b2b result", 32'({quotient, remainder}), {16'd2, 16'd1});
      @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         dd = 16'($urandom);
         dv = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom >> $urandom_range(0, 15));
         op_and_check("random", dd, dv, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 14)) : -1);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
